// File: rtl/ccss_pkg.sv
// Shared types and constants for the CCSS multi-core system.
// Holds the data-memory arbiter state encoding and default widths.
package ccss_pkg;

    localparam int unsigned DMEM_ADDR_W       = 16;
    localparam int unsigned DMEM_DATA_W       = 16;
    localparam int unsigned NUM_CORES_DEFAULT = 4;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StIssue  = 2'd1,
        StRdWait = 2'd2
    } arb_state_e;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: finds the first requesting core after last_gnt_i,
// wrapping modulo NUM_CORES.
module rr_picker #(
    parameter int unsigned NUM_CORES = 4,
    parameter int unsigned IDX_W     = $clog2(NUM_CORES)
) (
    input  logic [NUM_CORES-1:0] req_i,
    input  logic [IDX_W-1:0]     last_gnt_i,
    output logic                 any_o,
    output logic [IDX_W-1:0]     winner_o
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        any_o    = 1'b0;
        winner_o = '0;
        cand     = '0;
        // Scan farthest-first so the nearest requester after last_gnt_i overwrites the rest.
        for (int i = int'(NUM_CORES); i >= 1; i--) begin
            cand = IDX_W'((int'(last_gnt_i) + i) % int'(NUM_CORES));
            if (req_i[cand]) begin
                any_o    = 1'b1;
                winner_o = cand;
            end
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous data memory between cores.
// One transaction at a time: a read completes before the next grant is issued.
module dmem_arbiter
    import ccss_pkg::*;
#(
    parameter int unsigned NUM_CORES = NUM_CORES_DEFAULT,
    parameter int unsigned ADDR_W    = DMEM_ADDR_W,
    parameter int unsigned DATA_W    = DMEM_DATA_W,
    parameter int unsigned RD_LAT    = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_CORES-1:0]        core_req,
    input  logic [NUM_CORES-1:0]        core_we,
    input  logic [NUM_CORES*ADDR_W-1:0] core_addr,
    input  logic [NUM_CORES*DATA_W-1:0] core_wdata,
    output logic [NUM_CORES-1:0]        core_gnt,
    output logic [NUM_CORES-1:0]        core_rvalid,
    output logic [DATA_W-1:0]           core_rdata,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_wdata,
    output logic                        mem_wren,
    input  logic [DATA_W-1:0]           mem_q,
    output logic                        busy,
    output logic [3:0]                  owner
);

    localparam int unsigned IDX_W     = $clog2(NUM_CORES);
    localparam logic [1:0]  RD_LAT_CNT = 2'(RD_LAT);

    arb_state_e             state_q, state_d;
    logic [1:0]             cnt_q, cnt_d;
    logic [IDX_W-1:0]       last_gnt_q, last_gnt_d;
    logic [3:0]             owner_q, owner_d;
    logic [ADDR_W-1:0]      mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]      mem_wdata_q, mem_wdata_d;
    logic                   mem_wren_q, mem_wren_d;
    logic [NUM_CORES-1:0]   core_gnt_q, core_gnt_d;
    logic [NUM_CORES-1:0]   core_rvalid_q, core_rvalid_d;
    logic [DATA_W-1:0]      core_rdata_q, core_rdata_d;

    logic                   pick_any;
    logic [IDX_W-1:0]       pick_idx;

    logic [ADDR_W-1:0]      addr_arr  [NUM_CORES];
    logic [DATA_W-1:0]      wdata_arr [NUM_CORES];

    for (genvar g = 0; g < NUM_CORES; g++) begin : g_unpack
        assign addr_arr[g]  = core_addr[g*ADDR_W +: ADDR_W];
        assign wdata_arr[g] = core_wdata[g*DATA_W +: DATA_W];
    end

    rr_picker #(
        .NUM_CORES (NUM_CORES),
        .IDX_W     (IDX_W)
    ) u_rr_picker (
        .req_i      (core_req),
        .last_gnt_i (last_gnt_q),
        .any_o      (pick_any),
        .winner_o   (pick_idx)
    );

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        last_gnt_d    = last_gnt_q;
        owner_d       = owner_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        mem_wren_d    = 1'b0;
        core_gnt_d    = '0;
        core_rvalid_d = '0;
        core_rdata_d  = core_rdata_q;

        case (state_q)
            StIdle: begin
                // Grant and operands are registered together so they appear in ISSUE.
                if (pick_any) begin
                    state_d     = StIssue;
                    last_gnt_d  = pick_idx;
                    owner_d     = 4'(pick_idx);
                    mem_addr_d  = addr_arr[pick_idx];
                    mem_wdata_d = wdata_arr[pick_idx];
                    mem_wren_d  = core_we[pick_idx];
                    core_gnt_d  = NUM_CORES'(1) << pick_idx;
                end
            end
            StIssue: begin
                if (mem_wren_q) begin
                    state_d = StIdle;
                end else begin
                    state_d = StRdWait;
                    cnt_d   = RD_LAT_CNT;
                end
            end
            StRdWait: begin
                cnt_d = cnt_q - 2'd1;
                // Memory q is valid in the cycle the counter is about to reach zero.
                if (cnt_q <= 2'd1) begin
                    state_d       = StIdle;
                    core_rdata_d  = mem_q;
                    core_rvalid_d = NUM_CORES'(1) << last_gnt_q;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            cnt_q         <= 2'd0;
            last_gnt_q    <= IDX_W'(NUM_CORES - 1);
            owner_q       <= 4'd0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            mem_wren_q    <= 1'b0;
            core_gnt_q    <= '0;
            core_rvalid_q <= '0;
            core_rdata_q  <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            last_gnt_q    <= last_gnt_d;
            owner_q       <= owner_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            mem_wren_q    <= mem_wren_d;
            core_gnt_q    <= core_gnt_d;
            core_rvalid_q <= core_rvalid_d;
            core_rdata_q  <= core_rdata_d;
        end
    end

    assign core_gnt    = core_gnt_q;
    assign core_rvalid = core_rvalid_q;
    assign core_rdata  = core_rdata_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign mem_wren    = mem_wren_q;
    assign owner       = owner_q;
    assign busy        = (state_q != StIdle);

    a_gnt_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(core_gnt_q));
    a_rvalid_onehot: assert property (@(posedge clk) disable iff (!rst_n)
                                      $onehot0(core_rvalid_q));

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed and scoreboard bench for dmem_arbiter: instance A (RD_LAT=1) carries most tests,
// instance B (RD_LAT=3) checks read blocking.
module tb_dmem_arbiter;

    logic        clk;
    logic        rst_n;

    logic [3:0]  a_req, a_we, a_gnt, a_rvalid, a_owner;
    logic [15:0] a_addr_arr [4];
    logic [15:0] a_wdata_arr [4];
    logic [63:0] a_addr, a_wdata;
    logic [15:0] a_rdata, a_mem_addr, a_mem_wdata, a_mem_q;
    logic        a_mem_wren, a_busy;

    logic [3:0]  b_req, b_we, b_gnt, b_rvalid, b_owner;
    logic [15:0] b_addr_arr [4];
    logic [15:0] b_wdata_arr [4];
    logic [63:0] b_addr, b_wdata;
    logic [15:0] b_rdata, b_mem_addr, b_mem_wdata, b_mem_q, b_p1, b_p2;
    logic        b_mem_wren, b_busy;

    logic        pre_we;
    logic [15:0] pre_addr, pre_data;
    logic [15:0] mem_a [0:65535];
    logic [15:0] mem_b [0:65535];

    int checks;
    int failures;

    assign a_addr  = {a_addr_arr[3], a_addr_arr[2], a_addr_arr[1], a_addr_arr[0]};
    assign a_wdata = {a_wdata_arr[3], a_wdata_arr[2], a_wdata_arr[1], a_wdata_arr[0]};
    assign b_addr  = {b_addr_arr[3], b_addr_arr[2], b_addr_arr[1], b_addr_arr[0]};
    assign b_wdata = {b_wdata_arr[3], b_wdata_arr[2], b_wdata_arr[1], b_wdata_arr[0]};

    dmem_arbiter #(.NUM_CORES(4), .ADDR_W(16), .DATA_W(16), .RD_LAT(1)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .core_req(a_req), .core_we(a_we), .core_addr(a_addr),
        .core_wdata(a_wdata), .core_gnt(a_gnt), .core_rvalid(a_rvalid), .core_rdata(a_rdata),
        .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_wren(a_mem_wren), .mem_q(a_mem_q),
        .busy(a_busy), .owner(a_owner)
    );

    dmem_arbiter #(.NUM_CORES(4), .ADDR_W(16), .DATA_W(16), .RD_LAT(3)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .core_req(b_req), .core_we(b_we), .core_addr(b_addr),
        .core_wdata(b_wdata), .core_gnt(b_gnt), .core_rvalid(b_rvalid), .core_rdata(b_rdata),
        .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_wren(b_mem_wren), .mem_q(b_mem_q),
        .busy(b_busy), .owner(b_owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous memories: A has one cycle of read latency, B has three.
    always @(posedge clk) begin
        if (pre_we) begin
            mem_a[pre_addr] <= pre_data;
            mem_b[pre_addr] <= pre_data;
        end else begin
            if (a_mem_wren) mem_a[a_mem_addr] <= a_mem_wdata;
            if (b_mem_wren) mem_b[b_mem_addr] <= b_mem_wdata;
        end
        a_mem_q <= mem_a[a_mem_addr];
        b_p1    <= mem_b[b_mem_addr];
        b_p2    <= b_p1;
        b_mem_q <= b_p2;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_set(input int i, input logic r, input logic w, input logic [15:0] ad,
                         input logic [15:0] d);
        logic [3:0] m;
        m = 4'b1 << i;
        a_req = r ? (a_req | m) : (a_req & ~m);
        a_we  = w ? (a_we | m) : (a_we & ~m);
        a_addr_arr[2'(i)]  = ad;
        a_wdata_arr[2'(i)] = d;
    endtask

    task automatic b_set(input int i, input logic r, input logic w, input logic [15:0] ad,
                         input logic [15:0] d);
        logic [3:0] m;
        m = 4'b1 << i;
        b_req = r ? (b_req | m) : (b_req & ~m);
        b_we  = w ? (b_we | m) : (b_we & ~m);
        b_addr_arr[2'(i)]  = ad;
        b_wdata_arr[2'(i)] = d;
    endtask

    typedef struct {
        logic [3:0]  req;
        logic [15:0] base;
        logic [15:0] data;
        logic [3:0]  exp_gnt;
        logic [15:0] exp_addr;
        logic [15:0] exp_wdata;
        logic [3:0]  exp_owner;
    } vec_t;

    vec_t vecs [8];

    // Scoreboard state for the random phase.
    logic [15:0] sb_mem   [16];
    logic        sb_valid [16];
    logic        pend     [4];
    logic        rdw      [4];
    int          waitg    [4];
    logic        op_we    [4];
    logic [3:0]  op_off   [4];
    logic [15:0] op_data  [4];
    logic [15:0] exp_d    [4];
    logic        exp_v    [4];
    int          rd_gcyc  [4];
    int          cyc;

    task automatic handle_rvalid();
        for (int i = 0; i < 4; i++) begin
            logic [1:0] ci;
            ci = 2'(i);
            if (((a_rvalid >> i) & 4'd1) != 4'd0) begin
                chk("rand_rvalid_expected", 32'(rdw[ci]), 32'd1);
                if (rdw[ci]) begin
                    chk("rand_rvalid_latency", 32'(cyc - rd_gcyc[ci]), 32'd2);
                    if (exp_v[ci]) chk("rand_rdata", 32'(a_rdata), 32'(exp_d[ci]));
                    rdw[ci] = 1'b0;
                end
            end
        end
    endtask

    initial begin
        int grants;
        int rv_cyc, g3_cyc;
        logic [15:0] rv_data;
        int rr_win [6];
        int rr_cyc [6];
        int n;
        int exp_order [6];

        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        pre_we   = 1'b0;
        pre_addr = '0;
        pre_data = '0;
        a_req = 4'hF; a_we = 4'hF;
        b_req = 4'h0; b_we = 4'h0;
        for (int i = 0; i < 4; i++) begin
            a_addr_arr[i] = 16'h0; a_wdata_arr[i] = 16'h0;
            b_addr_arr[i] = 16'h0; b_wdata_arr[i] = 16'h0;
        end

        vecs[0] = '{4'b0100, 16'h0020, 16'h1000, 4'b0100, 16'h0022, 16'h1002, 4'd2};
        vecs[1] = '{4'b0011, 16'h0030, 16'h2000, 4'b0001, 16'h0030, 16'h2000, 4'd0};
        vecs[2] = '{4'b1111, 16'h0040, 16'h3000, 4'b0010, 16'h0041, 16'h3001, 4'd1};
        vecs[3] = '{4'b1001, 16'h0050, 16'h4000, 4'b1000, 16'h0053, 16'h4003, 4'd3};
        vecs[4] = '{4'b1000, 16'h0060, 16'h5000, 4'b1000, 16'h0063, 16'h5003, 4'd3};
        vecs[5] = '{4'b0110, 16'h0070, 16'h6000, 4'b0010, 16'h0071, 16'h6001, 4'd1};
        vecs[6] = '{4'b0001, 16'h0080, 16'h7000, 4'b0001, 16'h0080, 16'h7000, 4'd0};
        vecs[7] = '{4'b1100, 16'h0090, 16'h8000, 4'b0100, 16'h0092, 16'h8002, 4'd2};

        // Reset held with all cores requesting.
        repeat (3) tick();
        chk("rst_gnt", 32'(a_gnt), 32'd0);
        chk("rst_rvalid", 32'(a_rvalid), 32'd0);
        chk("rst_rdata", 32'(a_rdata), 32'd0);
        chk("rst_mem_addr", 32'(a_mem_addr), 32'd0);
        chk("rst_mem_wdata", 32'(a_mem_wdata), 32'd0);
        chk("rst_mem_wren", 32'(a_mem_wren), 32'd0);
        chk("rst_busy", 32'(a_busy), 32'd0);
        chk("rst_owner", 32'(a_owner), 32'd0);
        a_req = 4'h0; a_we = 4'h0;
        @(negedge clk);
        rst_n = 1'b1;

        pre_we = 1'b1; pre_addr = 16'h0020; pre_data = 16'h1234;
        tick();
        pre_addr = 16'h0040; pre_data = 16'hCAFE;
        tick();
        pre_we = 1'b0;

        // Core 0 alone writes 0xBEEF to 0x0010.
        a_set(0, 1'b1, 1'b1, 16'h0010, 16'hBEEF);
        tick();
        chk("w0_gnt", 32'(a_gnt), 32'b0001);
        chk("w0_wren", 32'(a_mem_wren), 32'd1);
        chk("w0_addr", 32'(a_mem_addr), 32'h0010);
        chk("w0_wdata", 32'(a_mem_wdata), 32'hBEEF);
        chk("w0_busy", 32'(a_busy), 32'd1);
        a_req = 4'h0;
        tick();
        chk("w0_wren_low", 32'(a_mem_wren), 32'd0);
        chk("w0_idle", 32'(a_busy), 32'd0);

        // Table of write arbitration vectors.
        for (int v = 0; v < 8; v++) begin
            for (int i = 0; i < 4; i++) begin
                a_set(i, ((vecs[v].req >> i) & 4'd1) != 4'd0, 1'b1,
                      vecs[v].base + 16'(i), vecs[v].data + 16'(i));
            end
            tick();
            chk("tbl_gnt", 32'(a_gnt), 32'(vecs[v].exp_gnt));
            chk("tbl_wren", 32'(a_mem_wren), 32'd1);
            chk("tbl_addr", 32'(a_mem_addr), 32'(vecs[v].exp_addr));
            chk("tbl_wdata", 32'(a_mem_wdata), 32'(vecs[v].exp_wdata));
            chk("tbl_busy", 32'(a_busy), 32'd1);
            a_req = 4'h0;
            tick();
            chk("tbl_wren_low", 32'(a_mem_wren), 32'd0);
            chk("tbl_idle", 32'(a_busy), 32'd0);
            chk("tbl_owner", 32'(a_owner), 32'(vecs[v].exp_owner));
        end

        // Core 2 reads the preloaded word.
        a_set(2, 1'b1, 1'b0, 16'h0020, 16'h0);
        tick();
        chk("rd_gnt", 32'(a_gnt), 32'b0100);
        chk("rd_wren", 32'(a_mem_wren), 32'd0);
        a_req = 4'h0;
        tick();
        chk("rd_rvalid_early", 32'(a_rvalid), 32'd0);
        chk("rd_busy", 32'(a_busy), 32'd1);
        tick();
        chk("rd_rvalid", 32'(a_rvalid), 32'b0100);
        chk("rd_rdata", 32'(a_rdata), 32'h1234);
        chk("rd_owner", 32'(a_owner), 32'd2);
        chk("rd_idle", 32'(a_busy), 32'd0);
        tick();
        chk("rd_rvalid_pulse", 32'(a_rvalid), 32'd0);
        chk("rd_rdata_hold", 32'(a_rdata), 32'h1234);

        // B: core 1 read (RD_LAT=3) blocks core 3's write until after rvalid.
        b_set(1, 1'b1, 1'b0, 16'h0040, 16'h0);
        b_set(3, 1'b1, 1'b1, 16'h0041, 16'h5555);
        tick();
        chk("blk_gnt1", 32'(b_gnt), 32'b0010);
        b_set(1, 1'b0, 1'b0, 16'h0040, 16'h0);
        rv_cyc = -1; g3_cyc = -1; rv_data = '0;
        for (int k = 2; k <= 12; k++) begin
            tick();
            if (b_rvalid[1] && rv_cyc < 0) begin
                rv_cyc  = k;
                rv_data = b_rdata;
            end
            if (b_gnt[3] && g3_cyc < 0) begin
                g3_cyc = k;
                b_set(3, 1'b0, 1'b1, 16'h0041, 16'h5555);
            end
        end
        chk("blk_rvalid_cycle", 32'(rv_cyc), 32'd5);
        chk("blk_rdata", 32'(rv_data), 32'hCAFE);
        chk("blk_gnt3_cycle", 32'(g3_cyc), 32'd6);

        // Reset pulsed while A waits for read data.
        a_set(2, 1'b1, 1'b0, 16'h0020, 16'h0);
        tick();
        chk("mr_gnt", 32'(a_gnt), 32'b0100);
        a_req = 4'h0;
        tick();
        chk("mr_busy", 32'(a_busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mr_busy_async", 32'(a_busy), 32'd0);
        chk("mr_wren_async", 32'(a_mem_wren), 32'd0);
        tick();
        chk("mr_no_rvalid", 32'(a_rvalid), 32'd0);
        tick();
        chk("mr_no_rvalid2", 32'(a_rvalid), 32'd0);
        chk("mr_rdata", 32'(a_rdata), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // All cores hold write requests: rotation from core 0, one grant every 2 cycles.
        for (int i = 0; i < 4; i++) a_set(i, 1'b1, 1'b1, 16'h0200 + 16'(i), 16'hA000 + 16'(i));
        exp_order = '{0, 1, 2, 3, 0, 1};
        n = 0;
        for (int k = 1; k <= 20 && n < 6; k++) begin
            tick();
            if (a_gnt != 4'h0) begin
                rr_win[n] = -1;
                for (int i = 0; i < 4; i++) if (((a_gnt >> i) & 4'd1) != 4'd0) rr_win[n] = i;
                rr_cyc[n] = k;
                n++;
            end
        end
        chk("rr_count", 32'(n), 32'd6);
        for (int j = 0; j < 6; j++) begin
            if (j < n) begin
                chk("rr_order", 32'(rr_win[j]), 32'(exp_order[j]));
                chk("rr_cycle", 32'(rr_cyc[j]), 32'(1 + 2 * j));
            end
        end
        a_req = 4'h0;
        tick();
        tick();

        // Random mixed traffic with a scoreboard.
        for (int i = 0; i < 16; i++) begin
            sb_mem[i] = '0; sb_valid[i] = 1'b0;
        end
        for (int i = 0; i < 4; i++) begin
            pend[i] = 1'b0; rdw[i] = 1'b0; waitg[i] = 0; rd_gcyc[i] = 0;
            op_we[i] = 1'b0; op_off[i] = '0; op_data[i] = '0; exp_d[i] = '0; exp_v[i] = 1'b0;
        end
        grants = 0;
        cyc    = 0;
        while (grants < 1000 && cyc < 20000) begin
            for (int i = 0; i < 4; i++) begin
                logic [1:0] ci;
                ci = 2'(i);
                if (!pend[ci] && !rdw[ci] && $urandom_range(0, 2) == 0) begin
                    pend[ci]    = 1'b1;
                    waitg[ci]   = 0;
                    op_we[ci]   = ($urandom_range(0, 1) == 1);
                    op_off[ci]  = 4'($urandom_range(0, 15));
                    op_data[ci] = 16'($urandom_range(0, 65535));
                    a_set(i, 1'b1, op_we[ci], 16'h0100 + {12'h0, op_off[ci]}, op_data[ci]);
                end
            end
            tick();
            cyc++;
            if (a_gnt != 4'h0) begin
                logic [1:0] w;
                w = '0;
                grants++;
                chk("rand_gnt_onehot", 32'($countones(a_gnt)), 32'd1);
                for (int i = 0; i < 4; i++) if (((a_gnt >> i) & 4'd1) != 4'd0) w = 2'(i);
                for (int i = 0; i < 4; i++) begin
                    if (pend[2'(i)] && 2'(i) != w) waitg[2'(i)]++;
                end
                chk("rand_gnt_pending", 32'(pend[w]), 32'd1);
                chk("rand_fair", 32'(waitg[w] + 1 <= 4), 32'd1);
                pend[w] = 1'b0;
                a_set(int'(w), 1'b0, op_we[w], 16'h0100 + {12'h0, op_off[w]}, op_data[w]);
                if (op_we[w]) begin
                    sb_mem[op_off[w]]   = op_data[w];
                    sb_valid[op_off[w]] = 1'b1;
                end else begin
                    rdw[w]     = 1'b1;
                    exp_d[w]   = sb_mem[op_off[w]];
                    exp_v[w]   = sb_valid[op_off[w]];
                    rd_gcyc[w] = cyc;
                end
            end
            handle_rvalid();
        end
        chk("rand_grants_done", 32'(grants), 32'd1000);
        a_req = 4'h0;
        for (int k = 0; k < 8; k++) begin
            tick();
            cyc++;
            handle_rvalid();
        end
        for (int i = 0; i < 4; i++) chk("rand_reads_drained", 32'(rdw[i]), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shared data-memory arbiter for the multi-core CCSS matrix-multiply system. Each core's data-memory port (address register, data register, memory write strobe, memory read buffer) connects to one requester slot. The arbiter grants one core at a time, in round-robin order, access to a single-port synchronous data memory. It performs one transaction at a time, so a read completes before the next grant is issued.

## Interface
Parameters:
- NUM_CORES, 4, number of requesting cores (2..16)
- ADDR_W, 16, data-memory address width
- DATA_W, 16, data-memory word width
- RD_LAT, 1, data-memory read latency in clocks from address/clock edge to valid q (1..3)

Ports:
- clk  in  1  single system clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- core_req  in  NUM_CORES  per-core access request, level
- core_we  in  NUM_CORES  per-core 1=write, 0=read
- core_addr  in  NUM_CORES*ADDR_W  flattened; core i at [i*ADDR_W +: ADDR_W]
- core_wdata  in  NUM_CORES*DATA_W  flattened write data
- core_gnt  out  NUM_CORES  one-hot, one-cycle grant pulse
- core_rvalid  out  NUM_CORES  one-hot, one-cycle read-data-valid pulse
- core_rdata  out  DATA_W  read data, broadcast to all cores, qualified by core_rvalid
- mem_addr  out  ADDR_W  to data-memory address
- mem_wdata  out  DATA_W  to data-memory data
- mem_wren  out  1  to data-memory write enable
- mem_q  in  DATA_W  from data-memory q
- busy  out  1  high while not IDLE
- owner  out  4  index of current or last granted core

## Operation
- FSM states: IDLE, ISSUE, RDWAIT.
- IDLE: if any core_req is high, select the winner and latch its we/addr/wdata into mem_* registers. Next state is ISSUE. Otherwise stay in IDLE with mem_wren=0.
- Winner selection is round-robin. Search starts at last_gnt+1 and wraps modulo NUM_CORES. last_gnt resets to NUM_CORES-1, so core 0 wins first after reset.
- ISSUE, one cycle: core_gnt[winner]=1. mem_wren=we. last_gnt and owner are updated to the winner.
  - Write: next state is IDLE.
  - Read: next state is RDWAIT, with its counter loaded to RD_LAT.
- RDWAIT: the counter decrements each cycle. At 0, mem_q is captured into core_rdata, core_rvalid[owner] pulses for one cycle, and the next state is IDLE.
- Requester rules:
  - A core holds req/we/addr/wdata stable from assertion until its gnt.
  - After gnt, the core drops req or presents the next access.
  - After a read gnt, the core waits for rvalid before reusing the data.
  - A core that drops req before gnt commits a protocol violation. The arbiter still completes whatever it latched.
- Fairness: with all cores requesting continuously, each core is granted exactly once per NUM_CORES grants.
- core_rdata holds its last value until the next read completes.

## Timing
- Reset values: state=IDLE, core_gnt=0, core_rvalid=0, core_rdata=0, mem_addr=0, mem_wdata=0, mem_wren=0, busy=0, owner=0, last_gnt=NUM_CORES-1.
- A request visible in cycle t (state IDLE) gives gnt plus mem_* valid in cycle t+1.
- Write: mem_wren is high only in cycle t+1. The earliest next grant is in cycle t+3, so a single requester can complete one write per 2 cycles.
- Read: core_rvalid and core_rdata are valid in cycle t+2+RD_LAT.
- Simultaneous requests: exactly one gnt per ISSUE. Requests arriving during ISSUE or RDWAIT are evaluated in the next IDLE cycle.
- Wrap-around: with last_gnt=NUM_CORES-1, the search begins at core 0.
- Reset asserted mid-transaction: all outputs go to reset values immediately. A pending read is dropped with no rvalid, and mem_wren drops asynchronously.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Structure
- Shared package ccss_pkg holds:
  - the state enum (IDLE=2'd0, ISSUE=2'd1, RDWAIT=2'd2)
  - DMEM_ADDR_W/DMEM_DATA_W constants
  - the default NUM_CORES
- Sub-module rr_picker, combinational:
  - inputs: req vector, last_gnt index
  - outputs: any, winner index
  - parameterised by NUM_CORES
- The top level holds the FSM, RDWAIT counter, operand latches and output registers.

## Test plan
- Reset: rst_n low with requests active → all outputs 0, busy=0. After release, core 0 alone writes 0xBEEF to 0x0010 → gnt[0] at t+1 with mem_wren=1, mem_addr=0x0010, mem_wdata=0xBEEF.
- Read: memory model with RD_LAT=1 preloaded 0x1234 at 0x0020; core 2 reads → gnt[2] at t+1, rvalid[2] with core_rdata=0x1234 at t+3, other rvalid bits 0.
- Round-robin: all 4 cores hold write requests → grant order 0,1,2,3,0,1, with one grant every 2 cycles.
- Read blocking: core 1 reads (RD_LAT=3) while core 3 requests → gnt[3] not before the cycle after rvalid[1].
- Mid-read reset: rst_n pulsed low during RDWAIT → no rvalid. After release, core 0 is granted first again.
- Mixed random traffic (scoreboard): 1000 random reads/writes across 4 cores → every read returns the last written value, and no core waits more than NUM_CORES grants.
